// File: rtl/dot_scan_pkg.sv
// Shared definitions for the dot-matrix scanner.
// Provides the cell-code enum, glyph line patterns and a helper that returns the
// number of logical display lines a BOARD_N x BOARD_N board occupies.
// Optional feature macro used by the scanner: DOT_SCAN_CURSOR_EN.
package dot_scan_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_X     = 2'd1,
        CELL_O     = 2'd2,
        CELL_BLANK = 2'd3
    } cell_code_e;

    // Glyph rows, bit 2 = leftmost pixel. X and O share edge/middle rows inverted.
    localparam logic [2:0] GLYPH_NONE   = 3'b000;
    localparam logic [2:0] GLYPH_X_EDGE = 3'b101;
    localparam logic [2:0] GLYPH_X_MID  = 3'b010;
    localparam logic [2:0] GLYPH_O_EDGE = 3'b010;
    localparam logic [2:0] GLYPH_O_MID  = 3'b101;

    // Each cell is 3 lines plus a 1-line gap; the final gap is not displayed.
    function automatic int line_width(input int board_n);
        return 4 * board_n - 1;
    endfunction

    // One 3-pixel glyph row for a cell code; sub-line 3 is the inter-cell gap.
    function automatic logic [2:0] glyph_line(input logic [1:0] code, input logic [1:0] sub);
        logic [2:0] g;
        g = GLYPH_NONE;
        case (cell_code_e'(code))
            CELL_X:  g = (sub == 2'd1) ? GLYPH_X_MID : GLYPH_X_EDGE;
            CELL_O:  g = (sub == 2'd1) ? GLYPH_O_MID : GLYPH_O_EDGE;
            default: g = GLYPH_NONE;
        endcase
        if (sub == 2'd3) begin
            g = GLYPH_NONE;
        end
        return g;
    endfunction

endpackage

// File: rtl/dot_line_render.sv
// Combinational renderer: turns a board snapshot and a logical line number into
// the pixel pattern for one physical display row.
// Ports:
//   cells_i      board snapshot, cell (r,c) at [2*(r*BOARD_N+c) +: 2]
//   line_i       logical line (physical row + shift), no wrap
//   cursor_on_i  invert the cursor cell glyph on this line
//   cursor_idx_i cursor cell index r*BOARD_N+c; out-of-range selects nothing
//   pixels_o     COLS-bit row, cell c at [4*(BOARD_N-1-c) +: 3]
module dot_line_render
    import dot_scan_pkg::*;
#(
    parameter int BOARD_N = 3,
    parameter int COLS    = 14,
    parameter int LW      = 5,
    parameter int CIW     = 4
) (
    input  logic [2*BOARD_N*BOARD_N-1:0] cells_i,
    input  logic [LW-1:0]                line_i,
    input  logic                         cursor_on_i,
    input  logic [CIW-1:0]               cursor_idx_i,
    output logic [COLS-1:0]              pixels_o
);

    localparam int LINE_W = line_width(BOARD_N);

    logic [1:0] sub;
    logic [2:0] glyph;

    assign sub = line_i[1:0];

    always_comb begin
        pixels_o = '0;
        glyph    = '0;
        if (32'(line_i) < LINE_W) begin
            for (int r = 0; r < BOARD_N; r++) begin
                for (int c = 0; c < BOARD_N; c++) begin
                    if ((32'(line_i) >> 2) == 32'(r)) begin
                        glyph = glyph_line(cells_i[2*(r*BOARD_N+c) +: 2], sub);
                        // Gap lines stay dark even under the cursor.
                        if (cursor_on_i && sub != 2'd3 &&
                            32'(cursor_idx_i) == 32'(r*BOARD_N+c)) begin
                            glyph = ~glyph;
                        end
                        pixels_o[4*(BOARD_N-1-c) +: 3] = glyph;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-scanning dot-matrix driver. Steps one physical row every ROW_DIV clocks,
// snapshots the board when the scan wraps to row 0 so a frame never tears, and
// drives registered one-hot row select plus rendered column data.
// Optional feature: define DOT_SCAN_CURSOR_EN for a blinking cursor cell
// (adds cursor_en / cursor_idx ports and per-frame blink state).
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   board         2-bit cell codes, sampled only at row wrap
//   row_shift     logical-line offset, sampled at each row tick
//   cursor_en     cursor visible (cursor build)
//   cursor_idx    cursor cell r*BOARD_N+c (cursor build)
//   dot_row       one-hot active row
//   dot_col       pixels of active row, 1 = lit
//   frame_start   one-cycle pulse when row 0 is loaded
module dot_matrix_scanner
    import dot_scan_pkg::*;
#(
    parameter int BOARD_N      = 3,
    parameter int ROWS         = 10,
    parameter int COLS         = 14,
    parameter int ROW_DIV      = 12500,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [2*BOARD_N*BOARD_N-1:0]         board,
    input  logic [$clog2(ROWS)-1:0]              row_shift,
`ifdef DOT_SCAN_CURSOR_EN
    input  logic                                 cursor_en,
    input  logic [$clog2(BOARD_N*BOARD_N)-1:0]   cursor_idx,
`endif
    output logic [ROWS-1:0]                      dot_row,
    output logic [COLS-1:0]                      dot_col,
    output logic                                 frame_start
);

    localparam int RW  = $clog2(ROWS);
    localparam int LW  = RW + 1;
    localparam int PW  = $clog2(ROW_DIV);
    localparam int CIW = $clog2(BOARD_N*BOARD_N);
    localparam int NB  = 2*BOARD_N*BOARD_N;

    logic [PW-1:0]   presc_q, presc_d;
    logic [RW-1:0]   idx_q, idx_d;
    logic [NB-1:0]   shadow_q, shadow_d;
    logic [ROWS-1:0] dot_row_q, dot_row_d;
    logic [COLS-1:0] dot_col_q, dot_col_d;
    logic            frame_start_q, frame_start_d;

    logic            tick;
    logic            wrap;
    logic [LW-1:0]   line;
    logic [COLS-1:0] pixels;
    logic            cursor_on;
    logic [CIW-1:0]  cursor_sel;

    always_comb begin
        tick          = (presc_q == PW'(ROW_DIV - 1));
        wrap          = tick && (idx_q == RW'(ROWS - 1));
        presc_d       = tick ? '0 : presc_q + 1'b1;
        idx_d         = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        // Row 0 must render from the board captured this very cycle.
        shadow_d      = wrap ? board : shadow_q;
        line          = LW'(idx_d) + LW'(row_shift);
        dot_row_d     = tick ? (ROWS'(1) << idx_d) : dot_row_q;
        dot_col_d     = tick ? pixels : dot_col_q;
        frame_start_d = wrap;
    end

`ifdef DOT_SCAN_CURSOR_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;

    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (wrap) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    // New-frame phase so the whole frame, row 0 included, blinks together.
    assign cursor_on  = cursor_en & phase_d;
    assign cursor_sel = cursor_idx;
`else
    assign cursor_on  = 1'b0;
    assign cursor_sel = '0;
`endif

    dot_line_render #(
        .BOARD_N (BOARD_N),
        .COLS    (COLS),
        .LW      (LW),
        .CIW     (CIW)
    ) u_render (
        .cells_i      (shadow_d),
        .line_i       (line),
        .cursor_on_i  (cursor_on),
        .cursor_idx_i (cursor_sel),
        .pixels_o     (pixels)
    );

    // Index resets to the last row so the first tick wraps and loads row 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            idx_q         <= RW'(ROWS - 1);
            shadow_q      <= '0;
            dot_row_q     <= '0;
            dot_col_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            dot_row_q     <= dot_row_d;
            dot_col_q     <= dot_col_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign dot_row     = dot_row_q;
    assign dot_col     = dot_col_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Scoreboard bench for dot_matrix_scanner: a stimulus process drives board /
// row_shift and pushes the expected row load for every prescaler tick; a
// monitor pops and compares each time dot_row moves and checks hold cycles.
module tb_dot_matrix_scanner;

    localparam int BOARD_N      = 3;
    localparam int ROWS         = 10;
    localparam int COLS         = 14;
    localparam int ROW_DIV      = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int NC           = BOARD_N * BOARD_N;
    localparam int LINE_W       = 4 * BOARD_N - 1;
    localparam int FRAME        = ROWS * ROW_DIV;

    // Glyph pixel rows by cell code (rows 0..2), bit 2 = leftmost.
    localparam int GLYPH [4][3] = '{'{0, 0, 0}, '{5, 2, 5}, '{2, 5, 2}, '{0, 0, 0}};

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [2*NC-1:0]           board = '0;
    logic [$clog2(ROWS)-1:0]   row_shift = '0;
`ifdef DOT_SCAN_CURSOR_EN
    logic                      cursor_en = 1'b0;
    logic [$clog2(NC)-1:0]     cursor_idx = '0;
`endif
    logic [ROWS-1:0]           dot_row;
    logic [COLS-1:0]           dot_col;
    logic                      frame_start;

    always #5 clk = ~clk;

    dot_matrix_scanner #(
        .BOARD_N      (BOARD_N),
        .ROWS         (ROWS),
        .COLS         (COLS),
        .ROW_DIV      (ROW_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .board       (board),
        .row_shift   (row_shift),
`ifdef DOT_SCAN_CURSOR_EN
        .cursor_en   (cursor_en),
        .cursor_idx  (cursor_idx),
`endif
        .dot_row     (dot_row),
        .dot_col     (dot_col),
        .frame_start (frame_start)
    );

    typedef struct {
        int              cyc;
        logic [ROWS-1:0] row;
        logic [COLS-1:0] col;
        logic            fs;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int              scyc  = 0;
    int              ktick = 0;
    int              wraps = 0;
    logic [2*NC-1:0] snap  = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Picture of one logical line, straight from the glyph table and cell geometry.
    function automatic logic [COLS-1:0] model_line(input int line, input logic [2*NC-1:0] cells,
                                                   input bit cur_on, input int cur_idx);
        logic [COLS-1:0] out;
        int r, sub, code, g;
        out = '0;
        if (line >= LINE_W) return out;
        r   = line / 4;
        sub = line % 4;
        if (sub == 3) return out;
        for (int c = 0; c < BOARD_N; c++) begin
            code = int'((cells >> (2 * (r * BOARD_N + c))) & 2'b11);
            g    = GLYPH[code][sub];
            if (cur_on && cur_idx == r * BOARD_N + c) g = g ^ 7;
            out = out | (COLS'(g) << (4 * (BOARD_N - 1 - c)));
        end
        return out;
    endfunction

    function automatic logic [2*NC-1:0] rand_board();
        logic [2*NC-1:0] b;
        b = '0;
        for (int i = 0; i < NC; i++) b[2*i +: 2] = 2'($urandom_range(0, 3));
        return b;
    endfunction

    // Drive inputs at a falling edge; if the coming rising edge is a tick, record its result.
    task automatic step(input bit rnd);
        exp_t e;
        int   idx;
        bit   cur_on;
        int   cidx;
        if (rnd) begin
            if ($urandom_range(0, 7) == 0) board = rand_board();
            if ($urandom_range(0, 3) == 0) row_shift = $urandom_range(0, (1 << $clog2(ROWS)) - 1);
`ifdef DOT_SCAN_CURSOR_EN
            if ($urandom_range(0, 15) == 0) cursor_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) cursor_idx = $urandom_range(0, (1 << $clog2(NC)) - 1);
`endif
        end
        scyc++;
        if (scyc % ROW_DIV == 0) begin
            ktick++;
            idx = (ktick - 1) % ROWS;
            if (idx == 0) begin
                snap = board;
                wraps++;
            end
            cur_on = 1'b0;
            cidx   = 0;
`ifdef DOT_SCAN_CURSOR_EN
            cur_on = cursor_en && (((wraps / BLINK_FRAMES) % 2) == 1);
            cidx   = int'(cursor_idx);
`endif
            e.cyc = scyc;
            e.row = ROWS'(1) << idx;
            e.col = model_line(idx + int'(row_shift), snap, cur_on, cidx);
            e.fs  = (idx == 0);
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit rnd);
        repeat (n) step(rnd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_dot_row", 32'(dot_row), 32'(0));
        check("reset_dot_col", 32'(dot_col), 32'(0));
        check("reset_frame_start", 32'(frame_start), 32'(0));
        sb.delete();
        scyc  = 0;
        ktick = 0;
        wraps = 0;
        snap  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: a change of dot_row is a new row load; all other cycles must hold.
    initial begin
        logic [ROWS-1:0] prev_row;
        logic [COLS-1:0] hold_col;
        int              mcyc;
        exp_t            e;
        prev_row = '0;
        hold_col = '0;
        mcyc     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_row = '0;
                hold_col = '0;
                mcyc     = 0;
            end else begin
                mcyc++;
                if (dot_row !== prev_row) begin
                    if (sb.size() == 0) begin
                        check("unexpected_row_load", 32'(dot_row), 32'(prev_row));
                    end else begin
                        e = sb.pop_front();
                        check("row_load_cycle", 32'(mcyc), 32'(e.cyc));
                        check("dot_row", 32'(dot_row), 32'(e.row));
                        check("dot_col", 32'(dot_col), 32'(e.col));
                        check("frame_start", 32'(frame_start), 32'(e.fs));
                    end
                    prev_row = dot_row;
                    hold_col = dot_col;
                end else begin
                    check("hold_dot_col", 32'(dot_col), 32'(hold_col));
                    check("hold_frame_start", 32'(frame_start), 32'(0));
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_hold_row", 32'(dot_row), 32'(0));
        board     = 18'h00001;          // X at (0,0)
        row_shift = '0;
        rst       = 1'b0;
        run(FRAME + 2, 1'b0);
        board     = 18'h20000;          // O at (2,2)
        run(FRAME, 1'b0);
        row_shift = 4'd1;
        run(FRAME, 1'b0);
        board     = '1;                 // code 3 everywhere
        row_shift = '0;
        run(FRAME, 1'b0);
`ifdef DOT_SCAN_CURSOR_EN
        board      = '0;
        cursor_en  = 1'b1;
        cursor_idx = 4;
        run(4 * FRAME, 1'b0);
`endif
        run(20 * FRAME, 1'b1);
        run(5 * ROW_DIV + 1, 1'b1);
        do_reset();
        run(6 * FRAME, 1'b1);
        run(2, 1'b0);
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
